// File: rtl/fp8_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fp8_mul_arbiter
//
// Shares one external combinational FP8 (E4M3) multiplier among NUM_REQ
// requesters with round-robin arbitration. The block does no arithmetic. It
// picks one requester per cycle, registers that pair of operands toward the
// multiplier, registers the product that comes back, and pulses resp_valid
// for the requester that owns it. A grant in cycle N gives a response in
// cycle N+2, and the block sustains one multiply per cycle.
//
// Optional feature (compile-time macro FP8_MUL_ARB_STATS_EN):
//   When the macro is defined, each requester gets a 16-bit saturating grant
//   counter, read through stat_sel/stat_count and cleared by stat_clr.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   ID_W     requester index width, 2**ID_W >= NUM_REQ
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   en            when 0, no new grants are issued; in-flight ops still drain
//   req_valid     per-requester operand-pair valid
//   req_a/req_b   packed operands, requester i on bits [8i+7:8i]
//   req_ready     one-hot grant, combinational in the current cycle
//   mul_a/mul_b   registered operands to the shared multiplier
//   mul_product   combinational product returned by the shared multiplier
//   resp_valid    one-hot 1-cycle pulse naming the owner of resp_product
//   resp_product  registered product, broadcast to every requester
//   idle          no grant this cycle and both pipeline stages empty
//   stat_clr      (stats build) zero all grant counters; wins over increment
//   stat_sel      (stats build) counter select
//   stat_count    (stats build) counter[stat_sel], 0 for out-of-range select
// -----------------------------------------------------------------------------
module fp8_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [7:0]           mul_product,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [7:0]           resp_product,
    output logic                 idle
`ifdef FP8_MUL_ARB_STATS_EN
    ,
    input  logic                 stat_clr,
    input  logic [ID_W-1:0]      stat_sel,
    output logic [15:0]          stat_count
`endif
);

    localparam int PAD = 2 ** ID_W;

    // Index of the k-th requester after base, wrapping modulo NUM_REQ. The
    // result is always below NUM_REQ, so it never names a missing requester.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                 input int step);
        return ID_W'((int'(base) + step) % NUM_REQ);
    endfunction

    // Requester inputs are padded out to the full ID_W index space. This lets
    // an ID_W-bit index select them directly. Slots at or above NUM_REQ read
    // as zero and are never selected.
    logic [PAD-1:0] valid_pad;
    logic [7:0]     a_arr [PAD];
    logic [7:0]     b_arr [PAD];

    for (genvar g = 0; g < PAD; g++) begin : g_unpack
        if (g < NUM_REQ) begin : g_real
            assign valid_pad[g] = req_valid[g];
            assign a_arr[g]     = req_a[g*8 +: 8];
            assign b_arr[g]     = req_b[g*8 +: 8];
        end else begin : g_absent
            assign valid_pad[g] = 1'b0;
            assign a_arr[g]     = 8'h00;
            assign b_arr[g]     = 8'h00;
        end
    end

    logic [ID_W-1:0] last_q;
    logic            gnt_found;
    logic [ID_W-1:0] gnt_id;

    logic            vld_p0;
    logic [ID_W-1:0] id_p0;
    logic            vld_p1;
    logic [ID_W-1:0] id_p1;

    // Round-robin scan starting just after the last winner. The winner moves
    // to lowest priority, so a requester can win twice in a row only when
    // nobody else is asking.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        if (!rst && en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!gnt_found && valid_pad[rr_index(last_q, k)]) begin
                    gnt_found = 1'b1;
                    gnt_id    = rr_index(last_q, k);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = gnt_found && (gnt_id == ID_W'(i));
        end
    end

    // ---- stage 0: arbitration result -> operand registers ----
    // Operands hold their last values when there is no transfer. The
    // multiplier input then stays quiet, and stage 1 ignores it because
    // vld_p0 is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            id_p0  <= '0;
            mul_a  <= 8'h00;
            mul_b  <= 8'h00;
            last_q <= ID_W'(NUM_REQ - 1);
        end else begin
            vld_p0 <= gnt_found;
            if (gnt_found) begin
                id_p0  <= gnt_id;
                mul_a  <= a_arr[gnt_id];
                mul_b  <= b_arr[gnt_id];
                last_q <= gnt_id;
            end
        end
    end

    // ---- stage 1: multiplier product -> response register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            id_p1        <= '0;
            resp_product <= 8'h00;
        end else begin
            vld_p1 <= vld_p0;
            id_p1  <= id_p0;
            if (vld_p0) begin
                resp_product <= mul_product;
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = vld_p1 && (id_p1 == ID_W'(i));
        end
    end

    assign idle = ~vld_p0 & ~vld_p1 & ~(|req_ready);

`ifdef FP8_MUL_ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_REQ];

    // Clear wins over a same-cycle increment. Counters stick at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst || stat_clr) begin
                grant_cnt[i] <= 16'h0000;
            end else if (gnt_found && (gnt_id == ID_W'(i)) &&
                         (grant_cnt[i] != 16'hFFFF)) begin
                grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        stat_count = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_sel == ID_W'(i)) begin
                stat_count = grant_cnt[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp8_mul_arbiter
//
// Scoreboard bench for fp8_mul_arbiter. The bench acts as the shared
// multiplier through a value-level E4M3 model. A reference model predicts the
// round-robin grant every cycle. Each predicted transfer pushes its expected
// response, with owner, product and due cycle, into a queue. A separate
// monitor pops that queue whenever a response is due and compares it.
// -----------------------------------------------------------------------------
module tb_fp8_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           mul_a;
    logic [7:0]           mul_b;
    logic [7:0]           mul_product;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [7:0]           resp_product;
    logic                 idle;
`ifdef FP8_MUL_ARB_STATS_EN
    logic                 stat_clr;
    logic [ID_W-1:0]      stat_sel;
    logic [15:0]          stat_count;
`endif

    always #5 clk = ~clk;

    // Round to nearest, ties to even, after dropping sh low bits.
    function automatic int rne(input int x, input int sh);
        int q, r, half;
        q    = x >> sh;
        r    = x - (q << sh);
        half = 1 << (sh - 1);
        if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
        return q;
    endfunction

    // E4M3 multiply from the value definition. The magnitude is sig * 2**exp,
    // with 0x7F as NaN and overflow mapped to NaN.
    function automatic logic [7:0] fp8_mul(input logic [7:0] a, input logic [7:0] b);
        logic s;
        int   sa, sbm, ea, eb, p, e, msb, biased, m, sh;
        s = a[7] ^ b[7];
        if (a[6:0] == 7'h7F || b[6:0] == 7'h7F) return {s, 7'h7F};
        sa  = (a[6:3] == 4'd0) ? int'(a[2:0]) : 8 + int'(a[2:0]);
        ea  = (a[6:3] == 4'd0) ? -9 : int'(a[6:3]) - 10;
        sbm = (b[6:3] == 4'd0) ? int'(b[2:0]) : 8 + int'(b[2:0]);
        eb  = (b[6:3] == 4'd0) ? -9 : int'(b[6:3]) - 10;
        p = sa * sbm;
        e = ea + eb;
        if (p == 0) return {s, 7'h00};
        msb = 0;
        for (int k = 0; k < 8; k++) if (((p >> k) % 2) == 1) msb = k;
        biased = msb + e + 7;
        if (biased >= 1) begin
            sh = msb - 3;
            m  = (sh > 0) ? rne(p, sh) : (p << (-sh));
            if (m == 16) begin
                m      = 8;
                biased = biased + 1;
            end
            if (biased > 15 || (biased == 15 && m == 15)) return {s, 7'h7F};
            return {s, 4'(biased), 3'(m - 8)};
        end
        sh = -(e + 9);
        m  = (sh > 0) ? rne(p, sh) : (p << (-sh));
        return {s, 7'(m)};
    endfunction

    assign mul_product = fp8_mul(mul_a, mul_b);

    fp8_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_product  (mul_product),
        .resp_valid   (resp_valid),
        .resp_product (resp_product),
        .idle         (idle)
`ifdef FP8_MUL_ARB_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_sel     (stat_sel),
        .stat_count   (stat_count)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    typedef struct {
        int         id;
        logic [7:0] prod;
        int         due;
    } exp_t;

    exp_t sb[$];

    // Reference model state.
    int mdl_last = NUM_REQ - 1;
    bit mdl_v0   = 1'b0;
    bit mdl_v1   = 1'b0;
    int mdl_g    = -1;
`ifdef FP8_MUL_ARB_STATS_EN
    int mdl_cnt [NUM_REQ];
    initial for (int i = 0; i < NUM_REQ; i++) mdl_cnt[i] = 0;
`endif

    // First requester after 'last' in circular order that is asking.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Grant prediction, idle check and scoreboard push.
    always @(negedge clk) begin
        int                 g;
        logic [NUM_REQ-1:0] exp_rdy;
        if (chk_en) begin
            g = (rst || !en) ? -1 : rr_pick(req_valid, mdl_last);
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("idle", 32'(idle), 32'(!mdl_v0 && !mdl_v1 && g < 0));
`ifdef FP8_MUL_ARB_STATS_EN
            check("stat_count", 32'(stat_count),
                  (int'(stat_sel) < NUM_REQ) ? 32'(mdl_cnt[stat_sel]) : 32'd0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rst || stat_clr) mdl_cnt[i] = 0;
                else if (g == i && mdl_cnt[i] < 65535) mdl_cnt[i] = mdl_cnt[i] + 1;
            end
`endif
            if (rst) begin
                while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
                mdl_last = NUM_REQ - 1;
                mdl_v0   = 1'b0;
                mdl_v1   = 1'b0;
            end else begin
                mdl_v1 = mdl_v0;
                mdl_v0 = (g >= 0);
                if (g >= 0) begin
                    sb.push_back('{g, fp8_mul(req_a[g*8 +: 8], req_b[g*8 +: 8]), cyc + 2});
                    mdl_last = g;
                end
            end
            mdl_g = g;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (chk_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("resp_valid", 32'(resp_valid), 32'(1 << sb[0].id));
                check("resp_product", 32'(resp_product), 32'(sb[0].prod));
                void'(sb.pop_front());
            end else if (resp_valid !== '0) begin
                check("resp_valid_unexpected", 32'(resp_valid), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle; the requester granted last cycle presents a new pair.
    task automatic cycle_next();
        tick();
        if (mdl_g >= 0) begin
            req_a[mdl_g*8 +: 8] = 8'($urandom);
            req_b[mdl_g*8 +: 8] = 8'($urandom);
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
`ifdef FP8_MUL_ARB_STATS_EN
        stat_clr  = 1'b0;
        stat_sel  = '0;
`endif
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_mul_a", 32'(mul_a), 32'h00);
        check("reset_mul_b", 32'(mul_b), 32'h00);
        check("reset_resp_product", 32'(resp_product), 32'h00);
        check("reset_resp_valid", 32'(resp_valid), 32'h0);
        tick();
        rst = 1'b0;

        // Single op on requester 2: 2.0 * 1.5 = 3.0.
        req_valid        = 4'b0100;
        req_a[23:16]     = 8'h40;
        req_b[23:16]     = 8'h3C;
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        check("single_resp_valid", 32'(resp_valid), 32'b0100);
        check("single_resp_product", 32'(resp_product), 32'h44);
        tick();
        @(negedge clk);
        check("single_idle", 32'(idle), 32'd1);
        tick();

        // All four requesters continuously valid.
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*8 +: 8] = 8'($urandom);
            req_b[i*8 +: 8] = 8'($urandom);
        end
        req_valid = 4'b1111;
        repeat (8) cycle_next();
        req_valid = '0;
        repeat (3) cycle_next();

        // Make requester 1 the last winner, then 1 and 3 compete.
        req_valid = 4'b0010;
        cycle_next();
        req_valid = 4'b1010;
        repeat (6) cycle_next();
        req_valid = '0;
        repeat (3) cycle_next();

        // Drop en with two ops in flight.
        req_valid = 4'b1111;
        repeat (2) cycle_next();
        en = 1'b0;
        repeat (4) cycle_next();
        en        = 1'b1;
        req_valid = '0;
        cycle_next();

        // Reset one cycle after a grant.
        req_valid = 4'b1111;
        cycle_next();
        rst       = 1'b1;
        req_valid = '0;
        cycle_next();
        rst       = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        check("post_rst_mul_a", 32'(mul_a), 32'h00);
        check("post_rst_mul_b", 32'(mul_b), 32'h00);
        check("post_rst_resp_product", 32'(resp_product), 32'h00);
        repeat (4) cycle_next();
        req_valid = '0;
        repeat (3) cycle_next();

`ifdef FP8_MUL_ARB_STATS_EN
        stat_clr = 1'b1;
        cycle_next();
        stat_clr  = 1'b0;
        req_valid = 4'b0010;
        repeat (5) cycle_next();
        req_valid = '0;
        stat_sel  = 3'd1;
        @(negedge clk);
        check("stat_five_grants", 32'(stat_count), 32'd5);
        cycle_next();
        req_valid = 4'b0010;
        stat_clr  = 1'b1;
        cycle_next();
        req_valid = '0;
        stat_clr  = 1'b0;
        @(negedge clk);
        check("stat_clr_priority", 32'(stat_count), 32'd0);
        repeat (3) cycle_next();
`endif

        // Randomized traffic; a waiting requester keeps its operands.
        repeat (3000) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || mdl_g == i) begin
                    req_valid[i]    = ($urandom_range(0, 99) < 55);
                    req_a[i*8 +: 8] = 8'($urandom);
                    req_b[i*8 +: 8] = 8'($urandom);
                end
            end
`ifdef FP8_MUL_ARB_STATS_EN
            stat_clr = ($urandom_range(0, 99) == 0);
            stat_sel = ID_W'($urandom_range(0, 7));
`endif
            tick();
        end

        rst       = 1'b0;
        en        = 1'b1;
        req_valid = '0;
`ifdef FP8_MUL_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        repeat (4) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
